regfile_2r1w_clr: RTL and testbench
===================================

Name: regfile_2r1w_clr

Overview:
Parametrised register file with two read ports and one write port, the successor to the single-port 8x4 regfile. Adds:
- write-to-read bypass
- optional hardwired-zero entry 0
- a hardware clear sequencer that zeroes every entry after reset or on request

Sits beside datapath ALUs as operand storage. Reads stay registered with 1-cycle latency, as in the previous generation.

Parameters:
B, 8, data width in bits
W, 2, address width; depth = 2**W entries
R0_ZERO, 0, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns the pre-write value

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; one clock, synchronous, active-high
wr_en  in  1  write request
w_addr  in  W  write address
w_data  in  B  write data
r0_addr  in  W  read port 0 address
r1_addr  in  W  read port 1 address
r0_data  out  B  read port 0 data, registered
r1_data  out  B  read port 1 data, registered
clr_req  in  1  single-cycle request to zero all entries
busy  out  1  clear sweep in progress
wr_drop  out  1  one-cycle pulse: a write was rejected

Behaviour:
- Reset (rst high at a clk edge):
  - r0_data = r1_data = 0, wr_drop = 0, busy = 1.
  - FSM enters CLEAR with sweep pointer ptr = 0.
  - The array is not written while rst is high.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req = 1: ptr = 0, busy = 1 from the next cycle.
  - CLEAR: each cycle with rst low, writes 0 to array[ptr] and increments ptr.
  - When ptr = 2**W-1 is written: -> IDLE, busy = 0 on the following cycle.
  - busy is high for exactly 2**W cycles after rst release or after clr_req is accepted.
- clr_req while in CLEAR is ignored; the sweep does not restart.
- Writes:
  - In IDLE, wr_en = 1 writes w_data to array[w_addr] at the edge.
  - If R0_ZERO = 1 and w_addr = 0, the write is discarded silently (no wr_drop).
  - In CLEAR, or in the IDLE cycle where clr_req = 1, wr_en is rejected: wr_drop = 1 for one cycle, array unchanged.
  - wr_drop is 0 in every other cycle.
- Reads:
  - Both ports update every cycle: rN_data <= value(rN_addr), 1-cycle latency.
  - While busy = 1 (CLEAR), both read outputs are forced to 0.
  - If R0_ZERO = 1 and rN_addr = 0, the read result is 0.
- Bypass:
  - Condition: BYPASS = 1, the write is accepted, and w_addr = rN_addr.
  - Then rN_data <= w_data in the same edge.
  - Both ports may bypass simultaneously.
  - With BYPASS = 0, the read returns the old array contents.
- Both read ports may address the same entry; both get identical data.
- Addresses wrap naturally in W bits; there is no out-of-range condition.
- rst mid-sweep: the sweep restarts from ptr = 0, and the full 2**W-cycle sweep runs again after release.
- Array storage: a flop array of 2**W x B, with no reset on the array itself. The array reaches a known state only through the sweep.

Decomposition:
- Shared package regfile_pkg:
  - FSM state encoding (ST_IDLE, ST_CLEAR)
  - a depth function DEPTH(W) = 2**W
- One natural sub-module: regfile_clr_seq, which contains the FSM, ptr counter and busy output. It provides clr_we and clr_addr to the array.
- The array, write arbitration, bypass muxes and read registers stay in the top module.

Test Plan (B=8, W=2 unless stated):
1. Reset sweep: pulse rst for 2 cycles, wr_en = 0.
   -> busy = 1 for exactly 4 cycles after release, then 0.
   -> reads of entries 0..3 return 0x00.
2. Write then dual read: write 0x01 to entry 0 and 0x02 to entry 1; set r0_addr = 0, r1_addr = 1.
   -> next cycle r0_data = 0x01, r1_data = 0x02.
   -> with r0_addr = r1_addr = 1, both ports return 0x02.
3. Bypass: entry 2 holds 0x11; write 0xFF to entry 2 with r0_addr = 2 in the same cycle.
   -> BYPASS = 1: r0_data = 0xFF next cycle.
   -> BYPASS = 0: r0_data = 0x11, then 0xFF one cycle later.
4. Clear request: fill entries with 0xA5; pulse clr_req; issue wr_en to entry 3 with 0x3C on the second busy cycle.
   -> wr_drop = 1 for one cycle, busy = 1 for 4 cycles, reads = 0 while busy.
   -> afterwards all entries read 0x00; entry 3 is not 0x3C.
5. R0_ZERO = 1: write 0x7E to entry 0 with r0_addr = 0.
   -> r0_data = 0x00, including via bypass; wr_drop stays 0.
6. Reset mid-sweep: assert rst on the 2nd cycle of a clr_req sweep, hold 1 cycle.
   -> outputs 0, busy stays 1 for a full 4 cycles after release, then all entries read 0x00.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding and depth helper for the clearing 2R1W register file
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int DEPTH(input int w);
        return 2 ** w;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: sweep sequencer that zeroes every entry after reset or on a clear request
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_req_i,
    output logic         busy_o,
    output logic         clr_start_o,
    output logic         clr_we_o,
    output logic [W-1:0] clr_addr_o
);

    state_e         state_q, state_d;
    logic   [W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = (ptr_q == W'(DEPTH(W) - 1)) ? ST_IDLE : ST_CLEAR;
        end else if (clr_req_i) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o      = state_q == ST_CLEAR;
    assign clr_start_o = (state_q == ST_IDLE) && clr_req_i;
    assign clr_we_o    = busy_o && !rst;
    assign clr_addr_o  = ptr_q;

endmodule

// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: 2-read/1-write register file with bypass, optional zero entry and clear sweep
module regfile_2r1w_clr
    import regfile_pkg::*;
#(
    parameter int B       = 8,
    parameter int W       = 2,
    parameter bit R0_ZERO = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic [W-1:0] r0_addr,
    input  logic [W-1:0] r1_addr,
    output logic [B-1:0] r0_data,
    output logic [B-1:0] r1_data,
    input  logic         clr_req,
    output logic         busy,
    output logic         wr_drop
);

    logic [B-1:0] mem_q [DEPTH(W)];
    logic [B-1:0] r0_data_d, r0_data_q, r1_data_d, r1_data_q;
    logic         wr_drop_d, wr_drop_q;
    logic         clr_start, clr_we, wr_ok, wr_eff, rd_zero;
    logic [W-1:0] clr_addr;

    regfile_clr_seq #(.W(W)) u_seq (
        .clk         (clk),
        .rst         (rst),
        .clr_req_i   (clr_req),
        .busy_o      (busy),
        .clr_start_o (clr_start),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    // the cycle that accepts a clear already counts as busy, so it blocks writes too
    assign wr_ok     = wr_en && !rst && !busy && !clr_start;
    assign wr_eff    = wr_ok && !(R0_ZERO && w_addr == '0);
    assign wr_drop_d = wr_en && !rst && (busy || clr_start);
    assign rd_zero   = rst || busy || clr_start;

    assign r0_data_d = (rd_zero || (R0_ZERO && r0_addr == '0)) ? '0 :
                       (BYPASS && wr_eff && w_addr == r0_addr) ? w_data : mem_q[r0_addr];
    assign r1_data_d = (rd_zero || (R0_ZERO && r1_addr == '0)) ? '0 :
                       (BYPASS && wr_eff && w_addr == r1_addr) ? w_data : mem_q[r1_addr];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_eff) begin
            mem_q[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        r0_data_q <= r0_data_d;
        r1_data_q <= r1_data_d;
        wr_drop_q <= wr_drop_d;
    end

    assign r0_data = r0_data_q;
    assign r1_data = r1_data_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb_regfile_2r1w_clr: three parameter variants driven in lockstep against a behavioural model
module tb_regfile_2r1w_clr;

    logic       clk = 1'b0;
    logic       rst, wr_en, clr_req;
    logic [1:0] w_addr, r0_addr, r1_addr;
    logic [7:0] w_data;
    logic [7:0] r0d [3];
    logic [7:0] r1d [3];
    logic       busy [3];
    logic       drop [3];

    always #5 clk = ~clk;

    regfile_2r1w_clr #(.B(8), .W(2), .R0_ZERO(1'b0), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_data(r0d[0]), .r1_data(r1d[0]),
        .clr_req(clr_req), .busy(busy[0]), .wr_drop(drop[0]));

    regfile_2r1w_clr #(.B(8), .W(2), .R0_ZERO(1'b0), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_data(r0d[1]), .r1_data(r1d[1]),
        .clr_req(clr_req), .busy(busy[1]), .wr_drop(drop[1]));

    regfile_2r1w_clr #(.B(8), .W(2), .R0_ZERO(1'b1), .BYPASS(1'b1)) u_r0z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_data(r0d[2]), .r1_data(r1d[2]),
        .clr_req(clr_req), .busy(busy[2]), .wr_drop(drop[2]));

    int n_vec = 0;
    int n_bad = 0;

    bit         byp [3] = '{1'b1, 1'b0, 1'b1};
    bit         r0z [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] m_mem [3][4];
    int         m_sweep [3] = '{0, 0, 0};
    logic [7:0] e_r0 [3];
    logic [7:0] e_r1 [3];
    logic       e_busy [3];
    logic       e_drop [3];

    function automatic logic [7:0] rd_model(input int i, input logic [1:0] a);
        if (r0z[i] && a == 2'd0) return 8'h00;
        if (byp[i] && wr_en && w_addr == a) return w_data;
        return m_mem[i][a];
    endfunction

    // m_sweep counts clear writes still owed; any nonzero value means busy
    task automatic model_step(input int i);
        if (rst) begin
            m_sweep[i] = 4;
            e_r0[i] = 8'h00; e_r1[i] = 8'h00; e_drop[i] = 1'b0;
        end else if (m_sweep[i] > 0) begin
            m_mem[i][4 - m_sweep[i]] = 8'h00;
            m_sweep[i] = m_sweep[i] - 1;
            e_r0[i] = 8'h00; e_r1[i] = 8'h00; e_drop[i] = wr_en;
        end else if (clr_req) begin
            m_sweep[i] = 4;
            e_r0[i] = 8'h00; e_r1[i] = 8'h00; e_drop[i] = wr_en;
        end else begin
            e_drop[i] = 1'b0;
            e_r0[i] = rd_model(i, r0_addr);
            e_r1[i] = rd_model(i, r1_addr);
            if (wr_en && !(r0z[i] && w_addr == 2'd0)) m_mem[i][w_addr] = w_data;
        end
        e_busy[i] = m_sweep[i] > 0;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        wr_en = 1'b1; w_data = v;
        for (int a = 0; a < 4; a++) begin
            w_addr = 2'(a);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
        w_addr = '0; w_data = '0; r0_addr = '0; r1_addr = '0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({r0d[i], r1d[i], busy[i], drop[i]} !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_state dut%0d got r0=%h r1=%h busy=%b drop=%b exp 00 00 1 0",
                         i, r0d[i], r1d[i], busy[i], drop[i]);
            end
        end
        rst = 1'b0;
        n = 0;
        while (busy[0] === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        n_vec++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL reset_busy_len got %0d cycles exp 4", n);
        end
        for (int a = 0; a < 4; a++) begin
            r0_addr = 2'(a); r1_addr = 2'(3 - a);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (r0d[i] !== 8'h00 || r1d[i] !== 8'h00) begin
                    n_bad++;
                    $display("FAIL reset_read dut%0d entry %0d got %h/%h exp 00/00", i, a, r0d[i], r1d[i]);
                end
            end
        end
    endtask

    task automatic test_write_dual_read();
        wr_en = 1'b1; w_addr = 2'd0; w_data = 8'h01;
        tick();
        w_addr = 2'd1; w_data = 8'h02;
        tick();
        wr_en = 1'b0; r0_addr = 2'd0; r1_addr = 2'd1;
        tick();
        n_vec++;
        if (r0d[0] !== 8'h01 || r1d[0] !== 8'h02) begin
            n_bad++;
            $display("FAIL dual_read got %h/%h exp 01/02", r0d[0], r1d[0]);
        end
        n_vec++;
        if (r0d[2] !== 8'h00 || r1d[2] !== 8'h02) begin
            n_bad++;
            $display("FAIL dual_read_r0zero got %h/%h exp 00/02", r0d[2], r1d[2]);
        end
        r0_addr = 2'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (r0d[i] !== 8'h02 || r1d[i] !== 8'h02) begin
                n_bad++;
                $display("FAIL same_addr dut%0d got %h/%h exp 02/02", i, r0d[i], r1d[i]);
            end
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; w_addr = 2'd2; w_data = 8'h11;
        tick();
        w_data = 8'hFF; r0_addr = 2'd2;
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (r0d[0] !== 8'hFF) begin
            n_bad++;
            $display("FAIL bypass_on got %h exp ff", r0d[0]);
        end
        n_vec++;
        if (r0d[1] !== 8'h11) begin
            n_bad++;
            $display("FAIL bypass_off_old got %h exp 11", r0d[1]);
        end
        tick();
        n_vec++;
        if (r0d[1] !== 8'hFF) begin
            n_bad++;
            $display("FAIL bypass_off_new got %h exp ff", r0d[1]);
        end
    endtask

    task automatic test_clear();
        int nb = 0;
        int nd = 0;
        fill(8'hA5);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (busy[0] === 1'b1) nb++;
            if (drop[0] === 1'b1) nd++;
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if ({r0d[i], r1d[i], busy[i], drop[i]} !== {e_r0[i], e_r1[i], e_busy[i], e_drop[i]}) begin
                    n_bad++;
                    $display("FAIL clear_seq dut%0d k=%0d got %h %h %b %b exp %h %h %b %b", i, k,
                             r0d[i], r1d[i], busy[i], drop[i], e_r0[i], e_r1[i], e_busy[i], e_drop[i]);
                end
            end
            wr_en = (k == 1); w_addr = 2'd3; w_data = 8'h3C;
            r0_addr = 2'(k); r1_addr = 2'd3;
            tick();
        end
        wr_en = 1'b0;
        n_vec++;
        if (nb !== 4 || nd !== 1) begin
            n_bad++;
            $display("FAIL clear_counts got busy=%0d drop=%0d exp busy=4 drop=1", nb, nd);
        end
        for (int a = 0; a < 4; a++) begin
            r0_addr = 2'(a); r1_addr = 2'(a);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (r0d[i] !== 8'h00 || r1d[i] !== 8'h00) begin
                    n_bad++;
                    $display("FAIL clear_read dut%0d entry %0d got %h/%h exp 00/00", i, a, r0d[i], r1d[i]);
                end
            end
        end
    endtask

    task automatic test_r0_zero();
        wr_en = 1'b1; w_addr = 2'd0; w_data = 8'h7E; r0_addr = 2'd0; r1_addr = 2'd0;
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (r0d[2] !== 8'h00 || drop[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL r0zero_bypass got %h drop=%b exp 00 drop=0", r0d[2], drop[2]);
        end
        n_vec++;
        if (r0d[0] !== 8'h7E) begin
            n_bad++;
            $display("FAIL r0plain_bypass got %h exp 7e", r0d[0]);
        end
        tick();
        n_vec++;
        if (r0d[2] !== 8'h00 || r1d[2] !== 8'h00 || r0d[1] !== 8'h7E) begin
            n_bad++;
            $display("FAIL r0zero_read got %h/%h plain %h exp 00/00 plain 7e", r0d[2], r1d[2], r0d[1]);
        end
    endtask

    task automatic test_mid_rst();
        int n;
        fill(8'h5A);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({r0d[i], r1d[i], busy[i], drop[i]} !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL midrst_state dut%0d got %h %h %b %b exp 00 00 1 0",
                         i, r0d[i], r1d[i], busy[i], drop[i]);
            end
        end
        rst = 1'b0;
        n = 0;
        while (busy[0] === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        n_vec++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL midrst_busy_len got %0d cycles exp 4", n);
        end
        for (int a = 0; a < 4; a++) begin
            r0_addr = 2'(a); r1_addr = 2'(a);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (r0d[i] !== 8'h00 || r1d[i] !== 8'h00) begin
                    n_bad++;
                    $display("FAIL midrst_read dut%0d entry %0d got %h/%h exp 00/00", i, a, r0d[i], r1d[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            rst     = ($urandom % 64) == 0;
            clr_req = ($urandom % 16) == 0;
            wr_en   = ($urandom % 2) == 0;
            w_addr  = 2'($urandom);
            w_data  = 8'($urandom);
            r0_addr = 2'($urandom);
            r1_addr = ($urandom % 4 == 0) ? w_addr : 2'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if ({r0d[i], r1d[i], busy[i], drop[i]} !== {e_r0[i], e_r1[i], e_busy[i], e_drop[i]}) begin
                    n_bad++;
                    $display("FAIL random dut%0d k=%0d got %h %h %b %b exp %h %h %b %b", i, k,
                             r0d[i], r1d[i], busy[i], drop[i], e_r0[i], e_r1[i], e_busy[i], e_drop[i]);
                end
            end
        end
        rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_dual_read();
        test_bypass();
        test_clear();
        test_r0_zero();
        test_mid_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
